// File: rtl/out_port_ctrl.sv
// Output-port sequencer: buffers OUT-instruction bytes in a small FIFO and hands
// them one at a time to the output register via an accept strobe and valid/ack handshake.
module out_port_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_accept,
   output logic                     out_valid,
   input  logic                     out_ack
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [WIDTH-1:0]   mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               overflow_r;
   logic [WIDTH-1:0]   out_data_r;
   logic               accept_r;
   logic               valid_r;
   logic               full_s;
   logic               push_s;
   logic               pop_s;

   // Full is judged on the pre-edge count, so a push while full is dropped even if a pop happens now.
   assign full_s = (count_r == CNT_DEPTH);
   assign push_s = wr_en & ~full_s;

   assign full       = full_s;
   assign count      = count_r;
   assign overflow   = overflow_r;
   assign out_data   = out_data_r;
   assign out_accept = accept_r;
   assign out_valid  = valid_r;

   // Next-state and pop decision; a pop always coincides with entry into LOAD.
   always_comb begin
      next_state_s = state_r;
      pop_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (count_r != CNT_ZERO) begin
               next_state_s = LOAD;
               pop_s        = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         LOAD: begin
            next_state_s = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (out_ack && (count_r != CNT_ZERO)) begin
               next_state_s = LOAD;
               pop_s        = 1'b1;
            end else if (out_ack) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = WAIT_ACK;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // FIFO storage; stale entries need no reset because the pointers are cleared.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // State, pointers, count, sticky overflow and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= CNT_ZERO;
         overflow_r <= 1'b0;
         out_data_r <= {WIDTH{1'b0}};
         accept_r   <= 1'b0;
         valid_r    <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         accept_r   <= (next_state_s == LOAD);
         valid_r    <= (next_state_s == WAIT_ACK);
         overflow_r <= overflow_r | (wr_en & full_s);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r   <= rd_ptr_r + PTR_ONE;
            out_data_r <= mem_r[rd_ptr_r];
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_out_port_ctrl.sv
// Directed testbench for out_port_ctrl: reset, single byte, burst, overflow,
// push/pop across pointer wrap, and reset mid-handshake.
module tb_out_port_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic [2:0] count;
   logic       overflow;
   logic [7:0] out_data;
   logic       out_accept;
   logic       out_valid;
   logic       out_ack;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] got [16];
   int         got_cyc [16];
   int         n_got;

   out_port_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .count(count), .overflow(overflow), .out_data(out_data),
      .out_accept(out_accept), .out_valid(out_valid), .out_ack(out_ack)
   );

   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; out_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic record_accept(input int cyc);
      if (out_accept && n_got < 16) begin
         got[n_got]     = out_data;
         got_cyc[n_got] = cyc;
         n_got++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({count, full, overflow, out_data, out_accept, out_valid} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got count=%0d full=%b ovf=%b data=%h acc=%b val=%b, want all 0",
                  count, full, overflow, out_data, out_accept, out_valid);
      end
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_accept, out_valid, count} !== 5'd0) begin
         n_fail++;
         $display("FAIL ack_in_idle: got acc=%b val=%b count=%0d, want 0 0 0", out_accept, out_valid, count);
      end
   endtask

   task automatic test_single();
      wr_en = 1'b1; wr_data = 8'h05;
      @(negedge clk);
      wr_en = 1'b0;
      n_checks++;
      if (count !== 3'd1 || out_accept !== 1'b0) begin
         n_fail++;
         $display("FAIL single_after_push: got count=%0d acc=%b, want 1 0", count, out_accept);
      end
      @(negedge clk);
      n_checks++;
      if (out_accept !== 1'b1 || out_data !== 8'h05 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_load: got acc=%b data=%h val=%b, want 1 05 0", out_accept, out_data, out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || out_accept !== 1'b0 || out_data !== 8'h05) begin
            n_fail++;
            $display("FAIL single_wait%0d: got val=%b acc=%b data=%h, want 1 0 05", i, out_valid, out_accept, out_data);
         end
      end
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 8'h05) begin
         n_fail++;
         $display("FAIL single_ack: got val=%b count=%0d data=%h, want 0 0 05", out_valid, count, out_data);
      end
      @(negedge clk);
      n_checks++;
      if (out_accept !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: got acc=%b val=%b, want 0 0", out_accept, out_valid);
      end
   endtask

   task automatic test_burst();
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h04; exp_b[3] = 8'h05;
      n_got = 0;
      out_ack = 1'b1;
      for (int c = 0; c < 14; c++) begin
         record_accept(c);
         wr_en   = (c < 4);
         wr_data = (c < 4) ? exp_b[c] : 8'h00;
         @(negedge clk);
      end
      out_ack = 1'b0;
      n_checks++;
      if (n_got !== 4) begin
         n_fail++;
         $display("FAIL burst_strobes: got %0d strobes, want 4", n_got);
      end
      for (int k = 0; k < 4 && k < n_got; k++) begin
         n_checks++;
         if (got[k] !== exp_b[k]) begin
            n_fail++;
            $display("FAIL burst_data%0d: got %h, want %h", k, got[k], exp_b[k]);
         end
         if (k > 0) begin
            n_checks++;
            if (got_cyc[k] - got_cyc[k-1] !== 2) begin
               n_fail++;
               $display("FAIL burst_spacing%0d: got %0d cycles, want 2", k, got_cyc[k] - got_cyc[k-1]);
            end
         end
      end
      n_checks++;
      if (overflow !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_end: got ovf=%b count=%0d val=%b, want 0 0 0", overflow, count, out_valid);
      end
   endtask

   task automatic test_overflow();
      n_got = 0;
      out_ack = 1'b0;
      for (int c = 0; c < 6; c++) begin
         record_accept(c);
         wr_en = 1'b1; wr_data = 8'h10 + 8'(c);
         @(negedge clk);
      end
      wr_en = 1'b0;
      n_checks++;
      if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h10) begin
         n_fail++;
         $display("FAIL ovf_state: got count=%0d full=%b ovf=%b val=%b data=%h, want 4 1 1 1 10",
                  count, full, overflow, out_valid, out_data);
      end
      out_ack = 1'b1;
      for (int c = 6; c < 20; c++) begin
         record_accept(c);
         @(negedge clk);
      end
      out_ack = 1'b0;
      n_checks++;
      if (n_got !== 5) begin
         n_fail++;
         $display("FAIL ovf_drain_count: got %0d strobes, want 5", n_got);
      end
      for (int k = 0; k < 5 && k < n_got; k++) begin
         n_checks++;
         if (got[k] !== 8'h10 + 8'(k)) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: got %h, want %h", k, got[k], 8'h10 + 8'(k));
         end
      end
      n_checks++;
      if (count !== 3'd0 || full !== 1'b0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: got count=%0d full=%b ovf=%b, want 0 0 1", count, full, overflow);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_ovf_cleared: got %b, want 0", overflow);
      end
      n_got = 0;
      for (int c = 0; c < 16; c++) begin
         record_accept(c);
         if (c == 4) begin
            n_checks++;
            if (count !== 3'd3 || out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL wrap_pre: got count=%0d val=%b, want 3 1", count, out_valid);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (count !== 3'd3 || out_accept !== 1'b1 || out_data !== 8'h21) begin
               n_fail++;
               $display("FAIL wrap_pushpop: got count=%0d acc=%b data=%h, want 3 1 21", count, out_accept, out_data);
            end
         end
         wr_en   = (c < 5);
         wr_data = 8'h20 + 8'(c);
         out_ack = (c >= 4);
         @(negedge clk);
      end
      out_ack = 1'b0;
      n_checks++;
      if (n_got !== 5) begin
         n_fail++;
         $display("FAIL wrap_strobes: got %0d, want 5", n_got);
      end
      for (int k = 0; k < 5 && k < n_got; k++) begin
         n_checks++;
         if (got[k] !== 8'h20 + 8'(k)) begin
            n_fail++;
            $display("FAIL wrap_order%0d: got %h, want %h", k, got[k], 8'h20 + 8'(k));
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         wr_en = 1'b1; wr_data = 8'h30 + 8'(c);
         @(negedge clk);
      end
      n_checks++;
      if (out_valid !== 1'b1 || count !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_setup: got val=%b count=%0d, want 1 2", out_valid, count);
      end
      reset = 1'b1; wr_en = 1'b1; wr_data = 8'h33;
      @(negedge clk);
      reset = 1'b0; wr_en = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || out_accept !== 1'b0 || count !== 3'd0 || full !== 1'b0 || out_data !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset: got val=%b acc=%b count=%0d full=%b data=%h, want 0 0 0 0 00",
                  out_valid, out_accept, count, full, out_data);
      end
      n_got = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         record_accept(c);
      end
      n_checks++;
      if (n_got !== 0 || count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_after: got strobes=%0d count=%0d val=%b, want 0 0 0", n_got, count, out_valid);
      end
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; out_ack = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
